// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bridge:
// FSM encoding, trace-entry layout, bus-error data, tag width.
package mmio_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int TAG_W = 4;
  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

  // trace entry: {id[2:0],we,to,1'b0,addr[25:0],data[31:0]}
  localparam int TR_DATA_LSB = 0;
  localparam int TR_ADDR_LSB = 32;
  localparam int TR_TO_BIT   = 59;
  localparam int TR_WE_BIT   = 60;
  localparam int TR_ID_LSB   = 61;

  function automatic logic [63:0] trace_pack(
    input logic [2:0]  id,
    input logic        we,
    input logic        to,
    input logic [25:0] addr,
    input logic [31:0] data
  );
    logic [63:0] e;
    e = '0;
    e[TR_ID_LSB +: 3]    = id;
    e[TR_WE_BIT]         = we;
    e[TR_TO_BIT]         = to;
    e[TR_ADDR_LSB +: 26] = addr;
    e[TR_DATA_LSB +: 32] = data;
    return e;
  endfunction

endpackage

// File: rtl/mmio_bridge_trace_fifo.sv
// Overwrite-oldest trace FIFO. Ports: clk, rst, push/din,
// pop, dout (oldest entry), count, ovf (sticky overwrite flag).
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             do_pop;
  logic             drop;

  assign full   = count == (AW+1)'(DEPTH);
  assign empty  = count == '0;
  assign do_pop = pop & ~empty;
  // a pop alongside a full push consumes the
  // oldest entry, so nothing is lost
  assign drop   = push & full & ~do_pop;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop | drop)
        rd_ptr <= rd_ptr + AW'(1);
      if (drop)
        ovf <= 1'b1;
      if (push & ~do_pop & ~full)
        count <= count + (AW+1)'(1);
      else if (do_pop & ~push)
        count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// MMIO router: tag decode, device req/ack with timeout,
// cache pass-through for unmatched addresses, trace log.
// Ports: pipeline dmem_*, cache dc_*, device dev_*,
// bus_err, trace_rd/trace_data/trace_count/trace_ovf.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int          NUM_DEV     = 4,
  parameter logic [31:0] DEV_TAGS    = 32'hFEDC,
  parameter int          TIMEOUT     = 255,
  parameter int          TO_W        = 8,
  parameter int          TRACE_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dmem_read_in,
  input  logic                          dmem_write_in,
  input  logic [29:0]                   dmem_addr,
  input  logic [3:0]                    dmem_byte_w_en,
  input  logic [31:0]                   data_from_reg,
  output logic [31:0]                   dmem_data_out,
  output logic                          mmio_stall,
  output logic                          dc_read_in,
  output logic                          dc_write_in,
  input  logic [31:0]                   dc_data_out,
  output logic [NUM_DEV-1:0]            dev_req,
  output logic                          dev_we,
  output logic [25:0]                   dev_addr,
  output logic [31:0]                   dev_wdata,
  output logic [3:0]                    dev_be,
  input  logic [32*NUM_DEV-1:0]         dev_rdata,
  input  logic [NUM_DEV-1:0]            dev_ack,
  output logic                          bus_err,
  input  logic                          trace_rd,
  output logic [63:0]                   trace_data,
  output logic [$clog2(TRACE_DEPTH):0]  trace_count,
  output logic                          trace_ovf
);

  state_t      state, state_n;
  logic        req, hit;
  logic [2:0]  hit_slot;
  logic [2:0]  slot_q;
  logic        we_q, to_q;
  logic [25:0] addr_q;
  logic [31:0] rdata_q, sel_rdata;
  logic        ack_sel, timeout, push;
  logic [TO_W-1:0] cnt;

  assign req = dmem_read_in | dmem_write_in;

  // descending scan so the lowest matching slot wins
  always_comb begin
    hit      = 1'b0;
    hit_slot = '0;
    for (int i = NUM_DEV-1; i >= 0; i--) begin
      if (DEV_TAGS[i*TAG_W +: TAG_W] == dmem_addr[29:26]) begin
        hit      = 1'b1;
        hit_slot = 3'(i);
      end
    end
  end

  always_comb begin
    ack_sel   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (slot_q == 3'(i)) begin
        ack_sel   = dev_ack[i];
        sel_rdata = dev_rdata[i*32 +: 32];
      end
    end
  end

  assign timeout = cnt == TO_W'(TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (hit & req) state_n = S_WAIT;
      S_WAIT:  if (ack_sel | timeout) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    mmio_stall = 1'b0;
    push       = 1'b0;
    unique case (state)
      S_IDLE:  mmio_stall = hit & req;
      S_WAIT:  mmio_stall = 1'b1;
      S_DONE:  push = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_DEV; i++)
      dev_req[i] = (state == S_WAIT) && (slot_q == 3'(i));
  end

  assign dc_read_in    = dmem_read_in & ~hit;
  assign dc_write_in   = dmem_write_in & ~hit;
  assign dmem_data_out = (state == S_DONE) ? rdata_q : dc_data_out;
  assign dev_we        = we_q;
  assign dev_addr      = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      dev_wdata <= '0;
      dev_be    <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      to_q      <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (hit & req) begin
          slot_q    <= hit_slot;
          we_q      <= dmem_write_in;
          addr_q    <= dmem_addr[25:0];
          dev_wdata <= data_from_reg;
          dev_be    <= dmem_byte_w_en;
          cnt       <= '0;
          to_q      <= 1'b0;
        end
        S_WAIT: if (ack_sel) begin
          rdata_q <= sel_rdata;
        end else if (timeout) begin
          rdata_q <= BUS_ERR_DATA;
          to_q    <= 1'b1;
          bus_err <= 1'b1;
        end else begin
          cnt <= cnt + TO_W'(1);
        end
        default: ;
      endcase
    end
  end

  // stores log the written data, loads the returned data
  trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (64)
  ) u_trace (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (trace_pack(slot_q, we_q, to_q, addr_q,
                       we_q ? dev_wdata : rdata_q)),
    .pop   (trace_rd),
    .dout  (trace_data),
    .count (trace_count),
    .ovf   (trace_ovf)
  );

endmodule

// File: tb/tb_mmio_bridge.sv
// Randomized scoreboard bench for mmio_bridge:
// pipeline stimulus, device responder, completion monitor.
module tb_mmio_bridge;

  localparam int NDEV = 4;
  localparam int TMO  = 4;
  localparam int TD   = 4;
  localparam logic [31:0] TAGS = 32'hFEDC;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_read_in, dmem_write_in;
  logic [29:0] dmem_addr;
  logic [3:0]  dmem_byte_w_en;
  logic [31:0] data_from_reg;
  logic [31:0] dmem_data_out;
  logic        mmio_stall, dc_read_in, dc_write_in;
  logic [31:0] dc_data_out;
  logic [NDEV-1:0] dev_req;
  logic        dev_we;
  logic [25:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [3:0]  dev_be;
  logic [32*NDEV-1:0] dev_rdata;
  logic [NDEV-1:0] dev_ack;
  logic        bus_err;
  logic        trace_rd;
  logic [63:0] trace_data;
  logic [2:0]  trace_count;
  logic        trace_ovf;

  mmio_bridge #(
    .NUM_DEV(NDEV), .DEV_TAGS(TAGS), .TIMEOUT(TMO),
    .TO_W(8), .TRACE_DEPTH(TD)
  ) dut (
    .clk(clk), .rst(rst),
    .dmem_read_in(dmem_read_in), .dmem_write_in(dmem_write_in),
    .dmem_addr(dmem_addr), .dmem_byte_w_en(dmem_byte_w_en),
    .data_from_reg(data_from_reg), .dmem_data_out(dmem_data_out),
    .mmio_stall(mmio_stall), .dc_read_in(dc_read_in),
    .dc_write_in(dc_write_in), .dc_data_out(dc_data_out),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .dev_be(dev_be), .dev_rdata(dev_rdata),
    .dev_ack(dev_ack), .bus_err(bus_err), .trace_rd(trace_rd),
    .trace_data(trace_data), .trace_count(trace_count),
    .trace_ovf(trace_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          stall;
    bit          we;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic        we;
    logic [25:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } dexp_t;

  exp_t        exp_q[$];
  dexp_t       dev_q[$];
  logic [63:0] tq[$];
  bit          m_ovf, m_berr;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cur_slot, cur_delay;
  bit          cur_to;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic int slot_of(input logic [3:0] tag);
    logic [31:0] t;
    t = TAGS;
    for (int i = 0; i < NDEV; i++)
      if (t[i*4 +: 4] == tag) return i;
    return -1;
  endfunction

  // completion monitor: counts stall cycles of the active
  // request and checks the result on the release cycle
  int stall_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_cnt = 0;
    end else if (dmem_read_in || dmem_write_in) begin
      if (mmio_stall) begin
        stall_cnt++;
      end else begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_completion: got data %h expected none",
                   dmem_data_out);
        end else begin
          e = exp_q.pop_front();
          chk("stall_cycles", 64'(stall_cnt), 64'(e.stall));
          if (!e.we) chk("load_data", 64'(dmem_data_out), 64'(e.data));
        end
        stall_cnt = 0;
      end
    end
  end

  // device responder: checks the request, acks after the
  // planned delay, adds ack noise on other slots
  int wcnt = 0;
  always @(negedge clk) begin
    dexp_t d;
    logic [3:0] noise;
    dev_ack = '0;
    if (rst) begin
      wcnt = 0;
    end else if (dev_req != '0) begin
      if (wcnt == 0) begin
        if (dev_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious_dev_req: got %b expected 0000", dev_req);
        end else begin
          d = dev_q.pop_front();
          chk("dev_req", 64'(dev_req), 64'(d.req));
          chk("dev_we", 64'(dev_we), 64'(d.we));
          chk("dev_addr", 64'(dev_addr), 64'(d.addr));
          chk("dev_wdata", 64'(dev_wdata), 64'(d.wd));
          chk("dev_be", 64'(dev_be), 64'(d.be));
        end
      end
      noise = 4'($urandom) & ~(4'b0001 << cur_slot);
      dev_ack = noise;
      if (!cur_to && wcnt == cur_delay) dev_ack[cur_slot] = 1'b1;
      wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  // call right after posedge+1; returns at posedge+1 after
  // completion with the request still driven
  task automatic run_txn(input logic [3:0] tag, input bit wr,
                         input int delay, input bit to,
                         input bit pop);
    logic [31:0] r, wd, dcd, rv;
    logic [3:0]  be;
    int          s, n;
    exp_t        e;
    dexp_t       d;
    r   = $urandom();
    wd  = $urandom();
    dcd = $urandom();
    be  = 4'($urandom());
    s   = slot_of(tag);
    rv  = '0;
    for (int i = 0; i < NDEV; i++) begin
      r = $urandom();
      dev_rdata[i*32 +: 32] = r;
      if (i == s) rv = r;
    end
    r = $urandom();
    cur_slot  = (s < 0) ? 0 : s;
    cur_delay = delay;
    cur_to    = to;
    e.we   = wr;
    e.data = (s < 0) ? dcd : (to ? 32'hDEADBEEF : rv);
    e.stall = (s < 0) ? 0 : (to ? TMO + 2 : delay + 2);
    exp_q.push_back(e);
    if (s >= 0) begin
      d.req  = 4'b0001 << s;
      d.we   = wr;
      d.addr = r[25:0];
      d.wd   = wd;
      d.be   = be;
      dev_q.push_back(d);
    end
    dmem_addr      = {tag, r[25:0]};
    dmem_read_in   = !wr;
    dmem_write_in  = wr;
    data_from_reg  = wd;
    dmem_byte_w_en = be;
    dc_data_out    = dcd;
    @(negedge clk);
    chk("dc_read_in", 64'(dc_read_in), 64'((s < 0) && !wr));
    chk("dc_write_in", 64'(dc_write_in), 64'((s < 0) && wr));
    n = 0;
    while (mmio_stall && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL stall_bound: got %0d cycles expected <= %0d", n, TMO + 2);
    end
    if (s >= 0 && to) m_berr = 1'b1;
    chk("bus_err", 64'(bus_err), 64'(m_berr));
    chk("trace_count", 64'(trace_count), 64'(tq.size()));
    chk("trace_ovf", 64'(trace_ovf), 64'(m_ovf));
    if (tq.size() > 0) chk("trace_data", trace_data, tq[0]);
    trace_rd = pop;
    if (pop && tq.size() > 0) void'(tq.pop_front());
    if (s >= 0) begin
      tq.push_back({3'(s), wr, to, 1'b0, r[25:0],
                    wr ? wd : e.data});
      if (tq.size() > TD) begin
        void'(tq.pop_front());
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    trace_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    dmem_read_in  = 1'b0;
    dmem_write_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_txn();
    logic [3:0] tag;
    int         k;
    bit         to;
    k   = $urandom_range(0, 7);
    tag = (k < 6) ? 4'(12 + $urandom_range(0, 3))
                  : 4'($urandom_range(0, 15));
    to  = $urandom_range(0, 7) == 0;
    run_txn(tag, 1'($urandom()), $urandom_range(0, 3), to,
            $urandom_range(0, 2) == 0);
    if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
  endtask

  initial begin
    dexp_t d;
    rst = 1'b1;
    dmem_read_in = 1'b0; dmem_write_in = 1'b0;
    dmem_addr = '0; dmem_byte_w_en = '0; data_from_reg = '0;
    dc_data_out = '0; dev_rdata = '0; trace_rd = 1'b0;
    cur_slot = 0; cur_delay = 0; cur_to = 1'b0;
    m_ovf = 1'b0; m_berr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 64'(mmio_stall), 64'(0));
    chk("rst_dev_req", 64'(dev_req), 64'(0));
    chk("rst_dev_we", 64'(dev_we), 64'(0));
    chk("rst_dev_wdata", 64'(dev_wdata), 64'(0));
    chk("rst_dev_be", 64'(dev_be), 64'(0));
    chk("rst_bus_err", 64'(bus_err), 64'(0));
    chk("rst_trace_count", 64'(trace_count), 64'(0));
    chk("rst_trace_ovf", 64'(trace_ovf), 64'(0));
    chk("rst_trace_data", trace_data, 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_txn(4'hE, 1'b1, 2, 1'b0, 1'b0);
    run_txn(4'hF, 1'b0, 0, 1'b0, 1'b0);
    idle(1);
    run_txn(4'hD, 1'b0, 0, 1'b1, 1'b0);
    run_txn(4'h0, 1'b0, 0, 1'b0, 1'b0);
    run_txn(4'hC, 1'b1, 1, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) rand_txn();

    // reset while a device is being waited on
    cur_slot = 2; cur_to = 1'b1;
    d.req = 4'b0100; d.we = 1'b0; d.addr = 26'h0123456;
    d.wd = data_from_reg; d.be = dmem_byte_w_en;
    dev_q.push_back(d);
    dmem_addr = {4'hE, 26'h0123456};
    dmem_read_in = 1'b1; dmem_write_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    dmem_read_in = 1'b0;
    #1;
    chk("rstw_dev_req", 64'(dev_req), 64'(0));
    chk("rstw_stall", 64'(mmio_stall), 64'(0));
    chk("rstw_trace_count", 64'(trace_count), 64'(0));
    chk("rstw_bus_err", 64'(bus_err), 64'(0));
    exp_q.delete(); dev_q.delete(); tq.delete();
    m_ovf = 1'b0; m_berr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_txn(4'hD, 1'b0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) rand_txn();
    idle(2);
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL pending_completions: got %0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
